// File: rtl/rice_decoder0.sv
// ---------------------------------------------------------------------------
// rice_decoder0
// Bit-serial Rice (k=0) decoder. Counts the zero-run q of each unary codeword
// (q zeros followed by a 1). On the stop bit it undoes the zig-zag fold and
// places the signed residual in a single-entry valid/ready output register.
//
// Parameters:
//   COUNT_WIDTH : width of the zero-run counter (equals the sample width, 16)
//
// Ports:
//   iClock     : clock, rising edge
//   iReset     : synchronous reset, active low
//   iBit       : next coded stream bit
//   iValid     : iBit valid this cycle
//   oReady     : bit accepted when iValid && oReady
//   oSample    : decoded signed residual
//   oBitsUsed  : codeword length q+1
//   oValid     : oSample/oBitsUsed valid
//   iReady     : downstream accepts the sample
//   oError     : sticky zero-run overflow flag (RICE_DECODER0_OVERFLOW_CHECK_EN)
//
// Configuration macro: RICE_DECODER0_OVERFLOW_CHECK_EN
//   defined   -> overflow of the zero-run counter stops the decoder in ERROR
//                until reset and raises oError
//   undefined -> the counter wraps silently and decoding continues
// ---------------------------------------------------------------------------
module rice_decoder0 #(
    parameter int COUNT_WIDTH = 16
) (
    input  logic        iClock,
    input  logic        iReset,
    input  logic        iBit,
    input  logic        iValid,
    output logic        oReady,
    output logic [15:0] oSample,
    output logic [16:0] oBitsUsed,
    output logic        oValid,
    input  logic        iReady
`ifdef RICE_DECODER0_OVERFLOW_CHECK_EN
    ,
    output logic        oError
`endif
);

`ifdef RICE_DECODER0_OVERFLOW_CHECK_EN
    typedef enum logic [0:0] {
        COUNT = 1'b0,
        ERROR = 1'b1
    } state_t;
`else
    typedef enum logic [0:0] {
        COUNT = 1'b0
    } state_t;
`endif

    state_t                 state, state_next;
    logic [COUNT_WIDTH-1:0] q, q_next;
    logic                   accept;
    logic                   stop;
    logic                   zero;
    logic [16:0]            q_ext;
    logic [15:0]            u;
    logic [15:0]            half;
    logic [15:0]            sample_next;
    logic [16:0]            bits_next;
`ifdef RICE_DECODER0_OVERFLOW_CHECK_EN
    logic                   ovf;
`endif

    // Next-state / datapath. oReady depends only on registered state and
    // iReady, so there is no combinational path from iBit to any output.
    always_comb begin
        state_next  = state;
        q_next      = q;
        oReady      = (state == COUNT) && (!oValid || iReady);
        accept      = iValid && oReady;
        stop        = accept && iBit;
        zero        = accept && !iBit;
        q_ext       = 17'(q);
        u           = q_ext[15:0];
        half        = u >> 1;
        // Zig-zag inverse: even u -> u/2, odd u -> -(u+1)/2 == ~(u>>1)
        sample_next = u[0] ? ~half : half;
        bits_next   = q_ext + 17'd1;
`ifdef RICE_DECODER0_OVERFLOW_CHECK_EN
        ovf         = zero && (q == {COUNT_WIDTH{1'b1}});
`endif
        if (stop) begin
            q_next = '0;
        end else if (zero) begin
            // Without the overflow check this wraps to 0 at the top of range.
            q_next = q + COUNT_WIDTH'(1);
`ifdef RICE_DECODER0_OVERFLOW_CHECK_EN
            if (ovf) begin
                state_next = ERROR;
            end
`endif
        end
    end

    always_ff @(posedge iClock) begin
        if (!iReset) begin
            state     <= COUNT;
            q         <= '0;
            oSample   <= '0;
            oBitsUsed <= '0;
            oValid    <= 1'b0;
`ifdef RICE_DECODER0_OVERFLOW_CHECK_EN
            oError    <= 1'b0;
`endif
        end else begin
            state <= state_next;
            q     <= q_next;
            // A stop bit can only be accepted when the register is empty or
            // draining this cycle, so loading here never overwrites a held
            // sample; a concurrent handshake simply keeps oValid high.
            if (stop) begin
                oSample   <= sample_next;
                oBitsUsed <= bits_next;
                oValid    <= 1'b1;
            end else if (iReady) begin
                oValid    <= 1'b0;
            end
`ifdef RICE_DECODER0_OVERFLOW_CHECK_EN
            if (ovf) begin
                oError <= 1'b1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_rice_decoder0.sv
module tb_rice_decoder0;

    typedef struct {
        logic [15:0] s;
        logic [16:0] b;
    } exp_t;

    logic        iClock = 1'b0;
    logic        iReset;
    logic        iBit, iValid, oReady, oValid, iReady;
    logic [15:0] oSample;
    logic [16:0] oBitsUsed;

    // Narrow-counter instance: exercises counter top-of-range cheaply.
    logic        s_bit, s_valid, s_ready, s_ovalid, s_iready;
    logic [15:0] s_sample;
    logic [16:0] s_bits;

`ifdef RICE_DECODER0_OVERFLOW_CHECK_EN
    logic        oError, s_error;
`endif

    int checks   = 0;
    int failures = 0;
    int rdy_mode = 1;  // 0 random, 1 always ready, 2 never ready

    exp_t exp_q[$];
    exp_t exp_s[$];

    rice_decoder0 #(.COUNT_WIDTH(16)) dut (
        .iClock(iClock), .iReset(iReset), .iBit(iBit), .iValid(iValid),
        .oReady(oReady), .oSample(oSample), .oBitsUsed(oBitsUsed),
        .oValid(oValid), .iReady(iReady)
`ifdef RICE_DECODER0_OVERFLOW_CHECK_EN
        , .oError(oError)
`endif
    );

    rice_decoder0 #(.COUNT_WIDTH(4)) dut_s (
        .iClock(iClock), .iReset(iReset), .iBit(s_bit), .iValid(s_valid),
        .oReady(s_ready), .oSample(s_sample), .oBitsUsed(s_bits),
        .oValid(s_ovalid), .iReady(s_iready)
`ifdef RICE_DECODER0_OVERFLOW_CHECK_EN
        , .oError(s_error)
`endif
    );

    always #5 iClock = ~iClock;

    // Reference model: residual from zero-run length by the zig-zag rule.
    function automatic exp_t model(longint q, int width);
        exp_t   e;
        longint qq, v;
        qq  = q % (longint'(1) << width);
        v   = (qq % 2 == 0) ? qq / 2 : -(qq + 1) / 2;
        e.s = 16'(v);
        e.b = 17'(qq + 1);
        return e;
    endfunction

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Downstream ready driver, updated shortly after each rising edge.
    always @(posedge iClock) begin
        #2;
        case (rdy_mode)
            0:       iReady = ($urandom_range(0, 3) != 0);
            1:       iReady = 1'b1;
            default: iReady = 1'b0;
        endcase
    end

    // Scoreboard monitors: a handshake seen at the falling edge completes at
    // the following rising edge.
    always @(negedge iClock) begin
        if (iReset && oValid && iReady) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_sample", oSample, 16'hxxxx === 16'h0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("sample", oSample, e.s);
                chk("bits_used", oBitsUsed, e.b);
            end
        end
    end

    always @(negedge iClock) begin
        if (iReset && s_ovalid && s_iready) begin
            if (exp_s.size() == 0) begin
                chk("unexpected_sample_s", s_sample, 16'hxxxx === 16'h0);
            end else begin
                exp_t e;
                e = exp_s.pop_front();
                chk("sample_s", s_sample, e.s);
                chk("bits_used_s", s_bits, e.b);
            end
        end
    end

    task automatic send_bit(input logic b, input bit gaps);
        int n;
        if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
                iValid = 1'b0;
                iBit   = 1'($urandom);
                @(posedge iClock); #1;
            end
        end
        iBit   = b;
        iValid = 1'b1;
        n      = 0;
        do begin
            @(negedge iClock);
            n++;
        end while (!oReady && n < 1000);
        if (!oReady) chk("accept_timeout", 0, 1);
        @(posedge iClock); #1;
        iValid = 1'b0;
    endtask

    task automatic send_codeword(input int q, input bit gaps);
        exp_q.push_back(model(q, 16));
        for (int i = 0; i < q; i++) send_bit(1'b0, gaps);
        send_bit(1'b1, gaps);
    endtask

    task automatic send_s_codeword(input int zeros);
        exp_s.push_back(model(zeros, 4));
        for (int i = 0; i < zeros; i++) begin
            s_bit = 1'b0; s_valid = 1'b1;
            @(posedge iClock); #1;
        end
        s_bit = 1'b1; s_valid = 1'b1;
        @(posedge iClock); #1;
        s_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || exp_s.size() != 0) && n < 2000) begin
            @(posedge iClock); #1;
            n++;
        end
        chk("drain_pending", exp_q.size() + exp_s.size(), 0);
        @(posedge iClock); #1;
    endtask

    initial begin
        iReset = 1'b0; iBit = 1'b0; iValid = 1'b0; iReady = 1'b1;
        s_bit = 1'b0; s_valid = 1'b0; s_iready = 1'b1;
        repeat (3) @(posedge iClock);
        @(negedge iClock);
        chk("reset_valid", oValid, 0);
        chk("reset_sample", oSample, 0);
        chk("reset_bits", oBitsUsed, 0);
`ifdef RICE_DECODER0_OVERFLOW_CHECK_EN
        chk("reset_error", oError, 0);
`endif
        @(posedge iClock); #1;
        iReset = 1'b1;
        @(negedge iClock);
        chk("reset_ready", oReady, 1);
        @(posedge iClock); #1;

        // Basic codewords with downstream always ready.
        send_codeword(0, 0);
        send_codeword(3, 0);
        send_codeword(4, 0);
        drain();

        // Back-pressure: first sample held, input stalled, nothing lost.
        rdy_mode = 2;
        repeat (2) @(posedge iClock); #1;
        send_codeword(0, 0);
        iBit = 1'b0; iValid = 1'b1;
        repeat (3) begin
            @(negedge iClock);
            chk("hold_ready", oReady, 0);
            chk("hold_valid", oValid, 1);
            chk("hold_sample", oSample, 0);
            chk("hold_bits", oBitsUsed, 1);
        end
        @(posedge iClock); #1;
        rdy_mode = 1;
        send_codeword(1, 0);
        drain();

        // Randomized codewords, gaps and back-pressure.
        rdy_mode = 0;
        for (int k = 0; k < 80; k++) send_codeword($urandom_range(0, 40), 1);
        rdy_mode = 1;
        drain();

        // Reset mid-codeword discards the partial run.
        for (int i = 0; i < 5; i++) send_bit(1'b0, 0);
        iReset = 1'b0;
        @(posedge iClock); #1;
        @(posedge iClock); #1;
        @(negedge iClock);
        chk("midreset_valid", oValid, 0);
        @(posedge iClock); #1;
        iReset = 1'b1;
        @(posedge iClock); #1;
        send_codeword(1, 0);
        drain();

        // Largest run the 16-bit counter holds.
        send_codeword(65535, 0);
        drain();

        // Narrow counter: top of range, then overflow behaviour.
        send_s_codeword(15);
        drain();
`ifdef RICE_DECODER0_OVERFLOW_CHECK_EN
        for (int i = 0; i < 16; i++) begin
            s_bit = 1'b0; s_valid = 1'b1;
            @(posedge iClock); #1;
        end
        s_bit = 1'b1;
        @(negedge iClock);
        chk("ovf_error", s_error, 1);
        chk("ovf_ready", s_ready, 0);
        repeat (3) @(posedge iClock);
        @(negedge iClock);
        chk("ovf_error_held", s_error, 1);
        chk("ovf_no_output", s_ovalid, 0);
        chk("ovf_ready_held", s_ready, 0);
        @(posedge iClock); #1;
        s_valid = 1'b0;
        iReset  = 1'b0;
        @(posedge iClock); #1;
        @(negedge iClock);
        chk("ovf_error_cleared", s_error, 0);
        @(posedge iClock); #1;
        iReset = 1'b1;
        @(negedge iClock);
        chk("ovf_ready_after_reset", s_ready, 1);
        @(posedge iClock); #1;
`else
        send_s_codeword(16);
        drain();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
